// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key-schedule controller and the expansion
// pipeline it drives.
//   DATA_W / KEY_L / NO_ROUNDS : default widths and round count (AES-128).
//   ks_state_e                 : key-schedule controller FSM state encoding.
//   RCON_TABLE / rcon()        : round constants, shared with the expansion block.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int DATA_W    = 128;
  localparam int KEY_L     = 128;
  localparam int NO_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT      = 2'd2,
    SWAP_WAIT = 2'd3
  } ks_state_e;

  // Round constant for round r+1 lives in byte r (byte 0 = round 1).
  localparam logic [NO_ROUNDS*8-1:0] RCON_TABLE = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON_TABLE[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/aes_key_bank.sv
// -----------------------------------------------------------------------------
// aes_key_bank
// Double-buffered round-key storage. The shadow bank is written from the
// expansion pipeline; the active bank feeds the cipher datapath and changes
// only as a whole-bank copy from shadow, so consumers never see a mix of
// old and new round keys.
// Ports:
//   clk, rst_ni  : clock, async active-low reset (clears both banks)
//   capture_i    : load shadow_i into the shadow bank
//   swap_i       : copy the shadow bank into the active bank
//   shadow_i     : all round keys from the expansion pipeline
//   active_o     : active bank contents
// -----------------------------------------------------------------------------
module aes_key_bank
  import aes_pkg::*;
#(
  parameter int BANK_W = aes_pkg::NO_ROUNDS * aes_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic              swap_i,
  input  logic [BANK_W-1:0] shadow_i,
  output logic [BANK_W-1:0] active_o
);

  logic [BANK_W-1:0] shadow_q;
  logic [BANK_W-1:0] active_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (capture_i) shadow_q <= shadow_i;
      if (swap_i)    active_q <= shadow_q;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// Accepts a cipher key, launches one expansion in the pipelined key-expansion
// block, captures the round keys when they arrive exactly NO_ROUNDS cycles
// after launch, and swaps them into the active bank once the cipher datapath
// is idle. Only KEY_L = 128 is supported.
//
// Handshake: a key transfers on a rising clk edge where key_valid && key_ready.
// key_ready is high only in IDLE and is forced low while key_flush is high;
// it does not depend on key_valid.
//
// Ports:
//   clk, reset     : clock, async active-low reset
//   key_valid/ready: key offer handshake, key_in is the offered key
//   key_flush      : drop active keys and abort any load (wins over all else)
//   cipher_busy    : holds the bank swap while the datapath is mid-block
//   exp_valid_in   : one-cycle launch pulse to the expansion pipeline
//   exp_key        : key driven to the expansion pipeline
//   exp_W          : all round keys from the pipeline
//   exp_valid_out  : per-stage valids from the pipeline
//   round_keys     : active bank to the cipher datapath
//   keys_valid     : active bank holds a complete key set
//   load_busy      : load in progress (state != IDLE), also FSM debug view
//   lat_err        : sticky, expansion result missing at the expected cycle
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl #(
  parameter int DATA_W    = aes_pkg::DATA_W,
  parameter int KEY_L     = aes_pkg::KEY_L,
  parameter int NO_ROUNDS = aes_pkg::NO_ROUNDS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic [KEY_L-1:0]            key_in,
  input  logic                        key_flush,
  input  logic                        cipher_busy,
  output logic                        exp_valid_in,
  output logic [KEY_L-1:0]            exp_key,
  input  logic [NO_ROUNDS*DATA_W-1:0] exp_W,
  input  logic [NO_ROUNDS-1:0]        exp_valid_out,
  output logic [NO_ROUNDS*DATA_W-1:0] round_keys,
  output logic                        keys_valid,
  output logic                        load_busy,
  output logic                        lat_err
);

  import aes_pkg::*;

  localparam int               CNT_W    = $clog2(NO_ROUNDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NO_ROUNDS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ks_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_L-1:0]   exp_key_q;
  logic               exp_valid_in_q;
  logic               keys_valid_q;
  logic               lat_err_q;

  logic               accept;
  logic               last_valid;
  logic               capture_en;
  logic               swap_en;

  assign key_ready  = (state_q == IDLE) && !key_flush;
  assign accept     = key_valid && key_ready;
  assign last_valid = exp_valid_out[NO_ROUNDS-1];

  // The final-stage valid is trusted only at the exact launch-relative cycle;
  // at any other count it belongs to a flushed or earlier launch.
  assign capture_en = (state_q == WAIT) && (cnt_q == CNT_LAST) && last_valid && !key_flush;
  assign swap_en    = (state_q == SWAP_WAIT) && !cipher_busy && !key_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      exp_key_q      <= '0;
      exp_valid_in_q <= 1'b0;
      keys_valid_q   <= 1'b0;
      lat_err_q      <= 1'b0;
    end else if (key_flush) begin
      // Abandon whatever is in flight; shadow contents are never swapped in
      // because a new capture must happen before the next SWAP_WAIT.
      state_q        <= IDLE;
      cnt_q          <= '0;
      exp_valid_in_q <= 1'b0;
      keys_valid_q   <= 1'b0;
    end else begin
      exp_valid_in_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            exp_key_q      <= key_in;
            lat_err_q      <= 1'b0;
            exp_valid_in_q <= 1'b1;
            state_q        <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q   <= CNT_ONE;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            if (last_valid) begin
              state_q <= SWAP_WAIT;
            end else begin
              lat_err_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        SWAP_WAIT: begin
          if (!cipher_busy) begin
            keys_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  aes_key_bank #(
    .BANK_W (NO_ROUNDS * DATA_W)
  ) u_bank (
    .clk       (clk),
    .rst_ni    (reset),
    .capture_i (capture_en),
    .swap_i    (swap_en),
    .shadow_i  (exp_W),
    .active_o  (round_keys)
  );

  assign exp_valid_in = exp_valid_in_q;
  assign exp_key      = exp_key_q;
  assign keys_valid   = keys_valid_q;
  assign load_busy    = (state_q != IDLE);
  assign lat_err      = lat_err_q;

`ifndef SYNTHESIS
  // The expansion pipeline is a pure shift of valids: a stage can only be
  // valid if the stage before it was valid one cycle earlier.
  for (genvar i = 0; i < NO_ROUNDS - 1; i++) begin : g_stage_chk
    a_stage_order: assert property (@(posedge clk) disable iff (!reset)
      exp_valid_out[i+1] |-> $past(exp_valid_out[i]));
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CNT_LAST);
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
// Directed bench for the key-schedule controller. A behavioural expansion
// pipeline (shift register of valids and keys) feeds the DUT. Expected launch
// keys and expected active-bank contents are queued when stimulus is issued;
// a monitor pops them whenever the DUT launches or its active bank changes.
// Cycle-exact timing is checked by the directed sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  localparam int RK_W = NO_ROUNDS * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              key_valid = 1'b0;
  logic              key_ready;
  logic [KEY_L-1:0]  key_in = '0;
  logic              key_flush = 1'b0;
  logic              cipher_busy = 1'b0;
  logic              exp_valid_in;
  logic [KEY_L-1:0]  exp_key;
  logic [RK_W-1:0]   exp_W;
  logic [NO_ROUNDS-1:0] exp_valid_out;
  logic [RK_W-1:0]   round_keys;
  logic              keys_valid;
  logic              load_busy;
  logic              lat_err;

  aes_key_sched_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .key_in        (key_in),
    .key_flush     (key_flush),
    .cipher_busy   (cipher_busy),
    .exp_valid_in  (exp_valid_in),
    .exp_key       (exp_key),
    .exp_W         (exp_W),
    .exp_valid_out (exp_valid_out),
    .round_keys    (round_keys),
    .keys_valid    (keys_valid),
    .load_busy     (load_busy),
    .lat_err       (lat_err)
  );

  // ---------------- vectors ----------------
  localparam logic [KEY_L-1:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [KEY_L-1:0] K2 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [KEY_L-1:0] K3 = 128'hdeadbeef_01234567_89abcdef_fedcba98;
  localparam logic [KEY_L-1:0] K4 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [KEY_L-1:0] K5 = 128'h55555555_aaaaaaaa_33333333_cccccccc;
  localparam logic [KEY_L-1:0] K6 = 128'h13579bdf_2468ace0_fedcba98_76543210;
  localparam logic [KEY_L-1:0] K7 = 128'h01010101_02020202_03030303_04040404;
  localparam logic [KEY_L-1:0] K8 = 128'h99999999_88888888_77777777_66666666;
  localparam logic [KEY_L-1:0] K9 = 128'hcafef00d_12345678_9abcdef0_0badf00d;

  localparam logic [DATA_W-1:0] K1_LAST = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  // FIPS-197 round keys 1..10 for K1, round 10 in the top slice.
  localparam logic [RK_W-1:0] K1_RK = {
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605
  };

  // Pipeline content: the real schedule for K1, a simple tagged pattern
  // (round r key = key + r) for every other key so the banks are distinct.
  function automatic logic [RK_W-1:0] expand(input logic [KEY_L-1:0] k);
    logic [RK_W-1:0] r;
    if (k == K1) begin
      r = K1_RK;
    end else begin
      for (int i = 0; i < NO_ROUNDS; i++) r[i*DATA_W +: DATA_W] = k + DATA_W'(i + 1);
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] last_rk(input logic [KEY_L-1:0] k);
    logic [RK_W-1:0] r;
    r = expand(k);
    return r[RK_W-1 -: DATA_W];
  endfunction

  // ---------------- expansion pipeline model ----------------
  logic [KEY_L-1:0]     pk [NO_ROUNDS] = '{default: '0};
  logic [NO_ROUNDS-1:0] pv = '0;
  logic                 drop_last = 1'b0;

  always @(posedge clk) begin
    pv    <= {pv[NO_ROUNDS-2:0], exp_valid_in};
    pk[0] <= exp_key;
    for (int i = 1; i < NO_ROUNDS; i++) pk[i] <= pk[i-1];
  end

  assign exp_valid_out = {pv[NO_ROUNDS-1] & ~drop_last, pv[NO_ROUNDS-2:0]};
  assign exp_W         = expand(pk[NO_ROUNDS-1]);

  // ---------------- scoreboard ----------------
  logic [RK_W-1:0]  exp_q[$];
  logic [KEY_L-1:0] launch_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_bit(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_bank(input string name, input logic [RK_W-1:0] got, input logic [RK_W-1:0] want);
    int bad;
    bad = -1;
    n_cmp++;
    for (int i = NO_ROUNDS - 1; i >= 0; i--)
      if (got[i*DATA_W +: DATA_W] !== want[i*DATA_W +: DATA_W]) bad = i;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: round %0d got %h, required %h (cycle %0d)", name, bad + 1,
               got[bad*DATA_W +: DATA_W], want[bad*DATA_W +: DATA_W], cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic [RK_W-1:0]  rk_prev = '0;
  logic [RK_W-1:0]  mon_rk;
  logic [KEY_L-1:0] mon_key;

  always @(negedge clk) begin
    if (reset && exp_valid_in) begin
      if (launch_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL launch_unexpected: launched %h, required no launch (cycle %0d)", exp_key, cyc);
      end else begin
        mon_key = launch_q.pop_front();
        check_word("launch_key", exp_key, mon_key);
      end
    end
    if (reset && round_keys !== rk_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL bank_unexpected: active last round %h changed, required no change (cycle %0d)",
                 round_keys[RK_W-1 -: DATA_W], cyc);
      end else begin
        mon_rk = exp_q.pop_front();
        check_bank("bank_swap", round_keys, mon_rk);
      end
    end
    rk_prev = round_keys;
  end

  // ---------------- driver tasks ----------------
  task automatic at_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      n_cmp++;
      n_err++;
      $display("FAIL sched: at cycle %0d, required %0d", cyc, c);
    end
  endtask

  // Offers k at the current negedge; returns at the negedge of the launch
  // cycle with acc = acceptance cycle.
  task automatic send_key(input logic [KEY_L-1:0] k, output int acc);
    int guard;
    guard = 0;
    launch_q.push_back(k);
    key_in    = k;
    key_valid = 1'b1;
    #1;
    while (!key_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!key_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: key_ready 0, required 1 (cycle %0d)", cyc);
    end
    acc = cyc;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_key_ready"},    key_ready,    1'b1);
    check_bit({tag, "_exp_valid_in"}, exp_valid_in, 1'b0);
    check_bit({tag, "_keys_valid"},   keys_valid,   1'b0);
    check_bit({tag, "_load_busy"},    load_busy,    1'b0);
    check_bit({tag, "_lat_err"},      lat_err,      1'b0);
    check_word({tag, "_exp_key"},     exp_key,      '0);
    check_bank({tag, "_round_keys"},  round_keys,   '0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #20000;
    n_err++;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a;
    int l;
    logic kv_drop;

    // Reset
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // 1: first load, datapath idle
    exp_q.push_back(expand(K1));
    send_key(K1, a);
    l = a + 1;
    check_bit("t1_launch_pulse", exp_valid_in, 1'b1);
    check_bit("t1_ready_low", key_ready, 1'b0);
    check_bit("t1_busy", load_busy, 1'b1);
    at_cyc(l + 1);
    check_bit("t1_launch_one_cycle", exp_valid_in, 1'b0);
    at_cyc(l + 10);
    check_bit("t1_kv_before_capture", keys_valid, 1'b0);
    at_cyc(l + 11);
    check_bit("t1_kv_in_swap_wait", keys_valid, 1'b0);
    check_bit("t1_busy_swap_wait", load_busy, 1'b1);
    at_cyc(l + 12);
    check_bit("t1_kv_set", keys_valid, 1'b1);
    check_word("t1_last_round_key", round_keys[RK_W-1 -: DATA_W], K1_LAST);
    check_bit("t1_idle", load_busy, 1'b0);
    check_bit("t1_ready_again", key_ready, 1'b1);

    // 2: load held off by a busy datapath for 7 cycles after capture
    exp_q.push_back(expand(K2));
    send_key(K2, a);
    l = a + 1;
    at_cyc(l + 9);
    cipher_busy = 1'b1;
    at_cyc(l + 11);
    check_word("t2_old_keys_held", round_keys[RK_W-1 -: DATA_W], K1_LAST);
    check_bit("t2_kv_held", keys_valid, 1'b1);
    at_cyc(l + 18);
    check_word("t2_old_keys_still", round_keys[RK_W-1 -: DATA_W], K1_LAST);
    check_bit("t2_still_waiting", load_busy, 1'b1);
    cipher_busy = 1'b0;
    at_cyc(l + 19);
    check_word("t2_swapped", round_keys[RK_W-1 -: DATA_W], last_rk(K2));
    check_bit("t2_idle", load_busy, 1'b0);

    // 3: reload while keys are valid, atomic bank switch
    exp_q.push_back(expand(K3));
    send_key(K3, a);
    l = a + 1;
    kv_drop = 1'b0;
    for (int c = l; c <= l + 12; c++) begin
      at_cyc(c);
      if (!keys_valid) kv_drop = 1'b1;
      if (c == l + 11) check_word("t3_old_before_swap", round_keys[RK_W-1 -: DATA_W], last_rk(K2));
    end
    check_bit("t3_kv_never_dropped", kv_drop, 1'b0);
    check_word("t3_new_after_swap", round_keys[RK_W-1 -: DATA_W], last_rk(K3));

    // 4: pipeline withholds the final valid
    drop_last = 1'b1;
    send_key(K4, a);
    l = a + 1;
    at_cyc(l + 10);
    check_bit("t4_no_err_yet", lat_err, 1'b0);
    at_cyc(l + 11);
    drop_last = 1'b0;
    check_bit("t4_lat_err", lat_err, 1'b1);
    check_bit("t4_idle", load_busy, 1'b0);
    check_bit("t4_ready", key_ready, 1'b1);
    check_bit("t4_kv_kept", keys_valid, 1'b1);
    check_word("t4_bank_intact", round_keys[RK_W-1 -: DATA_W], last_rk(K3));
    at_cyc(l + 12);
    check_bit("t4_lat_err_sticky", lat_err, 1'b1);
    exp_q.push_back(expand(K5));
    send_key(K5, a);
    l = a + 1;
    check_bit("t4_lat_err_cleared", lat_err, 1'b0);
    at_cyc(l + 12);
    check_word("t4_next_load", round_keys[RK_W-1 -: DATA_W], last_rk(K5));

    // 5: flush in WAIT, new key; stale valid lands at cnt=4 of the new load
    send_key(K6, a);
    l = a + 1;
    at_cyc(l + 4);
    key_flush = 1'b1;
    at_cyc(l + 5);
    check_bit("t5_kv_flushed", keys_valid, 1'b0);
    check_bit("t5_idle_after_flush", load_busy, 1'b0);
    key_flush = 1'b0;
    exp_q.push_back(expand(K7));
    send_key(K7, a);
    check_int("t5_accept_cycle", a, l + 5);
    l = a + 1;
    at_cyc(l + 6);
    check_bit("t5_stale_ignored_busy", load_busy, 1'b1);
    check_bit("t5_stale_ignored_kv", keys_valid, 1'b0);
    at_cyc(l + 11);
    check_bit("t5_kv_low_until_swap", keys_valid, 1'b0);
    at_cyc(l + 12);
    check_bit("t5_kv_set", keys_valid, 1'b1);
    check_word("t5_new_keys", round_keys[RK_W-1 -: DATA_W], last_rk(K7));

    // Flush wins over a same-cycle key offer
    key_in    = K8;
    key_valid = 1'b1;
    key_flush = 1'b1;
    #1;
    check_bit("flush_blocks_ready", key_ready, 1'b0);
    @(negedge clk);
    check_bit("flush_no_accept", load_busy, 1'b0);
    check_bit("flush_kv_clear", keys_valid, 1'b0);
    key_valid = 1'b0;
    key_flush = 1'b0;

    // 6: reset while holding in SWAP_WAIT
    cipher_busy = 1'b1;
    send_key(K9, a);
    l = a + 1;
    at_cyc(l + 12);
    check_bit("t6_in_swap_wait", load_busy, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("t6");
    cipher_busy = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_bit("t6_ready_after_release", key_ready, 1'b1);
    repeat (3) @(negedge clk);
    check_bit("t6_stays_idle", load_busy, 1'b0);
    check_bank("t6_no_partial_bank", round_keys, '0);

    // Every queued expectation must have been consumed
    check_int("exp_q_drained", exp_q.size(), 0);
    check_int("launch_q_drained", launch_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
